// File: rtl/digit_scan_ctrl_pkg.sv
// Shared display definitions for the digit scanner: FSM encoding,
// active-low segment glyphs and the helper that sizes the digit index.
package digit_scan_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GUARD = 2'd1;
  localparam logic [1:0] ST_ON    = 2'd2;

  // Every display pin is active-low, so "off" is a 1 on each line.
  localparam logic ALL_OFF = 1'b1;

  // Segment patterns, bit order g..a, 0 = segment lit.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/digit_scan_ctrl_if.sv
// Datapath-to-display bundle: result capture controls in, scanned pin
// drive and status out.
interface digit_scan_ctrl_if
  import digit_scan_ctrl_pkg::*;
#(
  parameter int DIGITS = 4
);
  localparam int IW = idx_w(DIGITS);

  logic                  en;
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_mask;
  logic                  blank_lz;

  logic [DIGITS-1:0]     anode;
  logic [6:0]            seg;
  logic                  dp;
  logic [IW-1:0]         digit_idx;
  logic                  frame_done;
  logic                  pending;

  modport master (
    output en, load, value, dp_mask, blank_lz,
    input  anode, seg, dp, digit_idx, frame_done, pending
  );

  modport slave (
    input  en, load, value, dp_mask, blank_lz,
    output anode, seg, dp, digit_idx, frame_done, pending
  );

endinterface

// File: rtl/digit_scan_ctrl_bcd_to_7seg.sv
// Nibble to active-low seven-segment glyph; non-decimal codes show a dash.
module bcd_to_7seg
  import digit_scan_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // NOTE: the default assignment ahead of the case keeps this purely
  // combinational even if a branch is later removed (no inferred latch).
  always_comb begin
    seg = SEG_DASH;
    case (nibble)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/digit_scan_ctrl_counter.sv
// Modulo-N up counter with synchronous clear and count enable; used as
// the per-slot prescaler of the digit scanner.
module digit_scan_ctrl_counter #(
  parameter int W = 17,
  parameter int N = 100000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         last
);

  assign last = (count == W'(N - 1));

  // NOTE: sequential state is written with <= only, so every register
  // samples the pre-edge values of its neighbours regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= last ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed scanner for the shared seven-segment display: double
// buffered result capture, per-slot ghosting guard, registered pin drive.
module digit_scan_ctrl
  import digit_scan_ctrl_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int PRESC  = 100000,
  parameter int GUARD  = 2000,
  parameter int PW     = 17
) (
  input  logic             clk,
  input  logic             reset,
  digit_scan_ctrl_if.slave bus
);

  localparam int            IW       = idx_w(DIGITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  logic [1:0]          state;
  logic [1:0]          state_nx;
  logic [PW-1:0]       cnt;
  logic                cnt_last;
  logic                presc_rst;
  logic [IW-1:0]       idx;

  logic [4*DIGITS-1:0] act_val;
  logic [DIGITS-1:0]   act_dp;
  logic [4*DIGITS-1:0] pend_val;
  logic [DIGITS-1:0]   pend_dp;
  logic                pend_q;

  logic                boundary;
  logic                transfer;
  logic                guard_done;
  logic                slot_end;
  logic                frame_end;
  logic [4*DIGITS-1:0] eff_val;
  logic [DIGITS-1:0]   eff_dp;
  logic [3:0]          nibble;
  logic [6:0]          glyph;
  logic [DIGITS-1:0]   blank_mask;

  logic [DIGITS-1:0]   anode_q;
  logic [6:0]          seg_q;
  logic                dp_q;
  logic                frame_done_q;

  assign presc_rst = ~reset;

  digit_scan_ctrl_counter #(
    .W (PW),
    .N (PRESC)
  ) u_presc (
    .clk   (clk),
    .rst   (presc_rst),
    .clr   (~bus.en),
    .en    (state != ST_IDLE),
    .count (cnt),
    .last  (cnt_last)
  );

  // A frame starts on the first cycle of digit 0's slot.
  assign boundary   = (state != ST_IDLE) && (cnt == '0) && (idx == '0);
  assign transfer   = boundary && pend_q;
  assign guard_done = (GUARD == 0) || (cnt == PW'(GUARD - 1));
  assign slot_end   = (state == ST_ON) && cnt_last;
  assign frame_end  = slot_end && (idx == LAST_IDX);

  // Show the incoming buffer on the boundary cycle itself so a frame never
  // mixes old and new digits, even with a zero-length guard.
  assign eff_val = transfer ? pend_val : act_val;
  assign eff_dp  = transfer ? pend_dp  : act_dp;
  assign nibble  = eff_val[4*int'(idx) +: 4];

  bcd_to_7seg u_dec (
    .nibble (nibble),
    .seg    (glyph)
  );

  always_comb begin
    logic all_zero;
    blank_mask = '0;
    all_zero   = 1'b1;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      all_zero      = all_zero && (eff_val[4*d +: 4] == 4'd0);
      blank_mask[d] = all_zero;
    end
  end

  always_comb begin
    state_nx = state;
    if (!bus.en) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state_nx = (GUARD == 0) ? ST_ON : ST_GUARD;
        ST_GUARD: if (guard_done) state_nx = ST_ON;
        ST_ON:    if (cnt_last) state_nx = (GUARD == 0) ? ST_ON : ST_GUARD;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      if (!bus.en) begin
        idx <= '0;
      end else if (slot_end) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
      end
    end
  end

  // NOTE: the buffers are a handful of flops, not a RAM, so they take the
  // async reset; the display must come up showing zeros, not stale data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_val <= '0;
      pend_dp  <= '0;
      pend_q   <= 1'b0;
      act_val  <= '0;
      act_dp   <= '0;
    end else begin
      if (transfer) begin
        act_val <= pend_val;
        act_dp  <= pend_dp;
      end
      // A load on the boundary cycle lands after the old contents moved out.
      if (bus.load) begin
        pend_val <= bus.value;
        pend_dp  <= bus.dp_mask;
        pend_q   <= 1'b1;
      end else if (transfer) begin
        pend_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      anode_q      <= {DIGITS{ALL_OFF}};
      seg_q        <= SEG_BLANK;
      dp_q         <= ALL_OFF;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= frame_end && bus.en;
      if (state == ST_IDLE) begin
        anode_q <= {DIGITS{ALL_OFF}};
        seg_q   <= SEG_BLANK;
        dp_q    <= ALL_OFF;
      end else begin
        anode_q <= (state == ST_ON) ? ~(DIGITS'(1) << idx) : {DIGITS{ALL_OFF}};
        seg_q   <= (bus.blank_lz && blank_mask[idx]) ? SEG_BLANK : glyph;
        dp_q    <= ~eff_dp[idx];
      end
    end
  end

  assign bus.anode      = anode_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.digit_idx  = idx;
  assign bus.frame_done = frame_done_q;
  assign bus.pending    = pend_q;

endmodule
